// File: rtl/z80_jp_cond_seq_if.sv
// Memory-read port between the JP cc,nn sequencer (master) and the core memory (slave).
interface z80_jp_cond_seq_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;

  modport master (output mem_rd, output mem_addr, input mem_data, input mem_ready);
  modport slave  (input mem_rd, input mem_addr, output mem_data, output mem_ready);
endinterface

// File: rtl/z80_jp_cond_seq.sv
// Z80 JP cc,nn micro-sequencer: fetches opcode + nn, evaluates cc against F, retires next IP.
// Optional macro Z80FI_EN builds the Z80FI retirement record; otherwise z80fi_* are tied to 0.
module z80_jp_cond_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] ip_in,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] ip_out,
  z80_jp_cond_seq_if.master mem,
  output logic        z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [2:0]  z80fi_insn_len,
  output logic [15:0] z80fi_reg_ip_in,
  output logic [15:0] z80fi_reg_ip_out,
  output logic [7:0]  z80fi_reg_f_in
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_RETIRE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ip_q, ip_d;
  logic [7:0]  f_q, f_d;
  logic [23:0] insn_q, insn_d;
  logic [15:0] ip_out_q, ip_out_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d, done_q, done_d, illegal_q, illegal_d, mem_rd_q, mem_rd_d;
  logic [2:0]  cc;
  logic        flag_sel;
  logic        cond_pass;

  // cc pairs share one flag; odd cc tests for the flag being set
  assign cc = insn_q[5:3];
  always_comb begin
    flag_sel = 1'b0;
    case (cc[2:1])
      2'd0:    flag_sel = f_q[6];
      2'd1:    flag_sel = f_q[0];
      2'd2:    flag_sel = f_q[2];
      default: flag_sel = f_q[7];
    endcase
  end
  assign cond_pass = (flag_sel == cc[0]);

  always_comb begin
    state_d   = state_q;
    ip_d      = ip_q;
    f_d       = f_q;
    insn_d    = insn_q;
    ip_out_d  = ip_out_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ip_d    = ip_in;
          f_d     = f_in;
          insn_d  = '0;
          state_d = S_FETCH_OP;
        end
      end
      S_FETCH_OP: begin
        if (mem.mem_ready) begin
          insn_d[7:0] = mem.mem_data;
          if ((mem.mem_data & 8'hC7) == 8'hC2) begin
            state_d = S_FETCH_LO;
          end else begin
            state_d   = S_RETIRE;
            illegal_d = 1'b1;
            ip_out_d  = ip_q + 16'd1;
          end
        end
      end
      S_FETCH_LO: begin
        if (mem.mem_ready) begin
          insn_d[15:8] = mem.mem_data;
          state_d      = S_FETCH_HI;
        end
      end
      S_FETCH_HI: begin
        if (mem.mem_ready) begin
          insn_d[23:16] = mem.mem_data;
          state_d       = S_RETIRE;
          ip_out_d      = cond_pass ? {mem.mem_data, insn_q[15:8]} : (ip_q + 16'd3);
        end
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_RETIRE);
    mem_rd_d   = (state_d == S_FETCH_OP) || (state_d == S_FETCH_LO) || (state_d == S_FETCH_HI);
    mem_addr_d = 16'd0;
    case (state_d)
      S_FETCH_OP: mem_addr_d = ip_d;
      S_FETCH_LO: mem_addr_d = ip_d + 16'd1;
      S_FETCH_HI: mem_addr_d = ip_d + 16'd2;
      default:    mem_addr_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ip_q       <= '0;
      f_q        <= '0;
      insn_q     <= '0;
      ip_out_q   <= '0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      f_q        <= f_d;
      insn_q     <= insn_d;
      ip_out_q   <= ip_out_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign illegal      = illegal_q;
  assign ip_out       = ip_out_q;
  assign mem.mem_rd   = mem_rd_q;
  assign mem.mem_addr = mem_addr_q;

`ifdef Z80FI_EN
  logic        fi_valid_q, fi_valid_d;
  logic [31:0] fi_insn_q, fi_insn_d;
  logic [2:0]  fi_len_q, fi_len_d;
  logic [15:0] fi_ip_in_q, fi_ip_in_d, fi_ip_out_q, fi_ip_out_d;
  logic [7:0]  fi_f_q, fi_f_d;

  // Record is loaded only for the RETIRE cycle and zero otherwise
  always_comb begin
    fi_valid_d  = 1'b0;
    fi_insn_d   = '0;
    fi_len_d    = '0;
    fi_ip_in_d  = '0;
    fi_ip_out_d = '0;
    fi_f_d      = '0;
    if (state_d == S_RETIRE) begin
      fi_valid_d  = !illegal_d;
      fi_insn_d   = {8'h00, insn_d};
      fi_len_d    = illegal_d ? 3'd1 : 3'd3;
      fi_ip_in_d  = ip_q;
      fi_ip_out_d = ip_out_d;
      fi_f_d      = f_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fi_valid_q  <= 1'b0;
      fi_insn_q   <= '0;
      fi_len_q    <= '0;
      fi_ip_in_q  <= '0;
      fi_ip_out_q <= '0;
      fi_f_q      <= '0;
    end else begin
      fi_valid_q  <= fi_valid_d;
      fi_insn_q   <= fi_insn_d;
      fi_len_q    <= fi_len_d;
      fi_ip_in_q  <= fi_ip_in_d;
      fi_ip_out_q <= fi_ip_out_d;
      fi_f_q      <= fi_f_d;
    end
  end

  assign z80fi_valid      = fi_valid_q;
  assign z80fi_insn       = fi_insn_q;
  assign z80fi_insn_len   = fi_len_q;
  assign z80fi_reg_ip_in  = fi_ip_in_q;
  assign z80fi_reg_ip_out = fi_ip_out_q;
  assign z80fi_reg_f_in   = fi_f_q;
`else
  logic unused_c;
  assign unused_c = ^{f_q, insn_q};

  assign z80fi_valid      = 1'b0;
  assign z80fi_insn       = 32'd0;
  assign z80fi_insn_len   = 3'd0;
  assign z80fi_reg_ip_in  = 16'd0;
  assign z80fi_reg_ip_out = 16'd0;
  assign z80fi_reg_f_in   = 8'd0;
`endif
endmodule

// File: tb/tb_z80_jp_cond_seq.sv
// Self-checking bench for z80_jp_cond_seq: scoreboarded JP cc,nn instructions with a wait-state memory.
module tb_z80_jp_cond_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ip_in = 16'd0;
  logic [7:0]  f_in = 8'd0;
  logic        busy, done, illegal;
  logic [15:0] ip_out;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out;
  logic [7:0]  z80fi_reg_f_in;

  z80_jp_cond_seq_if mem_if ();

  z80_jp_cond_seq dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .ip_in            (ip_in),
    .f_in             (f_in),
    .busy             (busy),
    .done             (done),
    .illegal          (illegal),
    .ip_out           (ip_out),
    .mem              (mem_if),
    .z80fi_valid      (z80fi_valid),
    .z80fi_insn       (z80fi_insn),
    .z80fi_insn_len   (z80fi_insn_len),
    .z80fi_reg_ip_in  (z80fi_reg_ip_in),
    .z80fi_reg_ip_out (z80fi_reg_ip_out),
    .z80fi_reg_f_in   (z80fi_reg_f_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ip_out;
    logic        illegal;
    logic        fi_valid;
    logic [31:0] fi_insn;
    logic [2:0]  fi_len;
    logic [15:0] fi_ip_in;
    logic [15:0] fi_ip_out;
    logic [7:0]  fi_f;
    int          lat;
    int          nreads;
    logic [15:0] ip;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_arr [0:65535];
  int          checks = 0;
  int          errors = 0;

  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_data  = 8'h00;
  end

  // Issue one instruction, act as the memory, and score the retirement against the queued model result
  task automatic run_insn(input logic [15:0] ip, input logic [7:0] f, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2, input int waits,
                          input bit hold_start, input string name);
    exp_t        e, got_e;
    logic        legal, taken, flagv;
    logic [2:0]  cc;
    logic [15:0] a1, a2, prev, hold_ip;
    logic [15:0] addrs[$];
    int          cyc, wcnt;
    bit          prev_wait, got;
    a1 = ip + 16'd1;
    a2 = ip + 16'd2;
    mem_arr[ip] = b0;
    mem_arr[a1] = b1;
    mem_arr[a2] = b2;
    legal = ((b0 & 8'hC7) == 8'hC2);
    cc = b0[5:3];
    case (cc[2:1])
      2'd0:    flagv = f[6];
      2'd1:    flagv = f[0];
      2'd2:    flagv = f[2];
      default: flagv = f[7];
    endcase
    taken = (flagv == cc[0]);
    e.ip        = ip;
    e.illegal   = !legal;
    e.ip_out    = !legal ? (ip + 16'd1) : (taken ? {b2, b1} : (ip + 16'd3));
    e.lat       = legal ? (4 + 3 * waits) : (2 + waits);
    e.nreads    = legal ? 3 : 1;
`ifdef Z80FI_EN
    e.fi_valid  = legal;
    e.fi_insn   = legal ? {8'h00, b2, b1, b0} : {24'h0, b0};
    e.fi_len    = legal ? 3'd3 : 3'd1;
    e.fi_ip_in  = ip;
    e.fi_ip_out = e.ip_out;
    e.fi_f      = f;
`else
    e.fi_valid  = 1'b0;
    e.fi_insn   = 32'd0;
    e.fi_len    = 3'd0;
    e.fi_ip_in  = 16'd0;
    e.fi_ip_out = 16'd0;
    e.fi_f      = 8'd0;
`endif
    sb.push_back(e);

    @(negedge clk);
    start = 1'b1;
    ip_in = ip;
    f_in  = f;
    mem_if.mem_ready = 1'b0;
    @(posedge clk);
    cyc = 0; wcnt = 0; prev_wait = 1'b0; got = 1'b0; prev = 16'd0;
    while (cyc < 40) begin
      cyc++;
      @(negedge clk);
      if (hold_start) begin
        ip_in = 16'hDEAD;
        f_in  = ~f;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        mem_if.mem_ready = 1'b0;
        break;
      end
      if (mem_if.mem_rd) begin
        if (prev_wait) begin
          checks++;
          if (mem_if.mem_addr !== prev) begin
            errors++;
            $display("FAIL %s addr_hold: got %h want %h", name, mem_if.mem_addr, prev);
          end
        end
        mem_if.mem_data = mem_arr[mem_if.mem_addr];
        if (wcnt >= waits) begin
          mem_if.mem_ready = 1'b1;
          addrs.push_back(mem_if.mem_addr);
          wcnt = 0;
          prev_wait = 1'b0;
        end else begin
          mem_if.mem_ready = 1'b0;
          wcnt++;
          prev_wait = 1'b1;
          prev = mem_if.mem_addr;
        end
      end else begin
        mem_if.mem_ready = 1'b0;
      end
      @(posedge clk);
    end

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: got no done want done within 40 cycles", name);
      start = 1'b0;
      return;
    end
    got_e = sb.pop_front();
    checks++;
    if (cyc !== got_e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, got_e.lat);
    end
    checks++;
    if (addrs.size() !== got_e.nreads) begin
      errors++;
      $display("FAIL %s nreads: got %0d want %0d", name, addrs.size(), got_e.nreads);
    end else begin
      for (int i = 0; i < addrs.size(); i++) begin
        checks++;
        if (addrs[i] !== 16'(got_e.ip + 16'(i))) begin
          errors++;
          $display("FAIL %s read_addr%0d: got %h want %h", name, i, addrs[i], 16'(got_e.ip + 16'(i)));
        end
      end
    end
    checks++;
    if (ip_out !== got_e.ip_out) begin
      errors++;
      $display("FAIL %s ip_out: got %h want %h", name, ip_out, got_e.ip_out);
    end
    checks++;
    if (illegal !== got_e.illegal) begin
      errors++;
      $display("FAIL %s illegal: got %b want %b", name, illegal, got_e.illegal);
    end
    checks++;
    if ({busy, mem_if.mem_rd} !== 2'b10) begin
      errors++;
      $display("FAIL %s retire_busy_rd: got %b want 10", name, {busy, mem_if.mem_rd});
    end
    checks++;
    if ({z80fi_valid, z80fi_insn, z80fi_insn_len} !== {got_e.fi_valid, got_e.fi_insn, got_e.fi_len}) begin
      errors++;
      $display("FAIL %s fi_insn: got v=%b insn=%h len=%0d want v=%b insn=%h len=%0d", name,
               z80fi_valid, z80fi_insn, z80fi_insn_len, got_e.fi_valid, got_e.fi_insn, got_e.fi_len);
    end
    checks++;
    if ({z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_f_in} !== {got_e.fi_ip_in, got_e.fi_ip_out, got_e.fi_f}) begin
      errors++;
      $display("FAIL %s fi_regs: got %h %h %h want %h %h %h", name, z80fi_reg_ip_in,
               z80fi_reg_ip_out, z80fi_reg_f_in, got_e.fi_ip_in, got_e.fi_ip_out, got_e.fi_f);
    end

    // Following cycle: back in IDLE even if start was held through RETIRE
    hold_ip = ip_out;
    @(negedge clk);
    checks++;
    if ({busy, done, illegal, z80fi_valid, z80fi_insn_len} !== 7'd0 || ip_out !== hold_ip) begin
      errors++;
      $display("FAIL %s post_retire: got busy=%b done=%b ill=%b v=%b len=%0d ip_out=%h want 0 0 0 0 0 %h",
               name, busy, done, illegal, z80fi_valid, z80fi_insn_len, ip_out, hold_ip);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, illegal, mem_if.mem_rd} !== 4'd0 || ip_out !== 16'd0 || mem_if.mem_addr !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b ill=%b rd=%b ip_out=%h addr=%h want all 0",
               busy, done, illegal, mem_if.mem_rd, ip_out, mem_if.mem_addr);
    end
    checks++;
    if ({z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_f_in} !== 91'd0) begin
      errors++;
      $display("FAIL reset_fi: got v=%b insn=%h len=%0d %h %h %h want all 0", z80fi_valid, z80fi_insn,
               z80fi_insn_len, z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_f_in);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    run_insn(16'h1000, 8'h40, 8'hC2, 8'h34, 8'h12, 0, 1'b0, "jp_nz_not_taken");
    run_insn(16'h1000, 8'h40, 8'hCA, 8'h34, 8'h12, 0, 1'b0, "jp_z_taken");
  endtask

  task automatic test_all_cc();
    logic [7:0] fv;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 2; k++) begin
        fv = (k == 0) ? 8'h00 : 8'hC5;
        run_insn(16'h4000 + 16'(c * 16), fv, 8'hC2 | 8'(c << 3), 8'h78, 8'h56, 0, 1'b0,
                 $sformatf("cc%0d_f%h", c, fv));
      end
    end
  endtask

  task automatic test_wrap_waits();
    run_insn(16'hFFFF, 8'h01, 8'hDA, 8'h00, 8'h80, 2, 1'b0, "wrap_waits");
  endtask

  task automatic test_illegal();
    run_insn(16'h2000, 8'h00, 8'h00, 8'h11, 8'h22, 0, 1'b0, "illegal_op");
    run_insn(16'hFFFF, 8'hFF, 8'hC3, 8'h11, 8'h22, 1, 1'b0, "illegal_c3_wrap");
  endtask

  task automatic test_back_to_back();
    run_insn(16'h5000, 8'h80, 8'hFA, 8'hEF, 8'hBE, 0, 1'b1, "b2b_held_start");
    run_insn(16'h5003, 8'h80, 8'hF2, 8'hEF, 8'hBE, 1, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_fetch();
    mem_arr[16'h3000] = 8'hC2;
    mem_arr[16'h3001] = 8'h00;
    mem_arr[16'h3002] = 8'h90;
    @(negedge clk);
    start = 1'b1;
    ip_in = 16'h3000;
    f_in  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mem_if.mem_data  = mem_arr[mem_if.mem_addr];
    mem_if.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    checks++;
    if (mem_if.mem_rd !== 1'b1 || mem_if.mem_addr !== 16'h3001) begin
      errors++;
      $display("FAIL rst_mid_lo: got rd=%b addr=%h want 1 3001", mem_if.mem_rd, mem_if.mem_addr);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_if.mem_rd, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_drop: got rd=%b busy=%b want 0 0", mem_if.mem_rd, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_nodone: got %b want 0", done);
      end
    end
    reset_n = 1'b1;
    run_insn(16'h3000, 8'h00, 8'hC2, 8'h00, 8'h90, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_cc();
    test_wrap_waits();
    test_illegal();
    test_back_to_back();
    test_reset_mid_fetch();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z80_jp_cond_seq.md
# z80_jp_cond_seq

Micro-sequencer that executes the Z80 `JP cc,nn` instruction end to end: fetches the opcode and the 16-bit immediate over the core memory-read port, evaluates the condition against F, computes the new IP, and emits the Z80FI retirement record that the per-instruction formal spec checkers consume. It sits between the core's instruction dispatcher and the memory port, and is the producing end of the Z80FI record for this instruction.

## Interface
- No parameters.
- `clk` in 1: sole clock, all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: dispatch request, sampled only in IDLE.
- `ip_in` in 16: IP of the instruction's first byte, captured on accepted `start`.
- `f_in` in 8: flag register, captured on accepted `start` (S=7, Z=6, H=4, PV=2, N=1, C=0).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in RETIRE.
- `illegal` out 1: valid with `done`; opcode did not match `11ccc010`.
- `ip_out` out 16: registered next IP, updated in RETIRE, held otherwise.
- `mem_rd` out 1: read request, high in the three fetch states.
- `mem_addr` out 16: read address, valid while `mem_rd`.
- `mem_data` in 8: read data, sampled on the edge where `mem_ready`=1.
- `mem_ready` in 1: completes the current read; low inserts wait states.
- `z80fi_valid` out 1, `z80fi_insn` out 32, `z80fi_insn_len` out 3, `z80fi_reg_ip_in` out 16, `z80fi_reg_ip_out` out 16, `z80fi_reg_f_in` out 8: retirement record, all registered.

## Operation
- States: IDLE, FETCH_OP, FETCH_LO, FETCH_HI, RETIRE.
- IDLE: `start`=1 captures `ip_in`/`f_in`, clears the insn register, → FETCH_OP. `start` outside IDLE is ignored, not queued.
- FETCH_OP: `mem_addr`=ip. On `mem_ready`: opcode → insn[7:0]; if opcode matches `11ccc010` → FETCH_LO, else → RETIRE with illegal.
- FETCH_LO: `mem_addr`=ip+1; on ready the byte goes to insn[15:8], → FETCH_HI.
- FETCH_HI: `mem_addr`=ip+2; on ready the byte goes to insn[23:16], → RETIRE.
- All address arithmetic is modulo 2^16 (ip=0xFFFF reads 0xFFFF, 0x0000, 0x0001).
- Condition cc=insn[5:3]: 0 NZ (Z=0), 1 Z (Z=1), 2 NC (C=0), 3 C (C=1), 4 PO (PV=0), 5 PE (PV=1), 6 P (S=0), 7 M (S=1). In each case the tested flag is F[flag] and the test passes when F[flag]==cc[0].
- Legal RETIRE: `ip_out` = nn (insn[23:8]) if the condition passes, else ip+3 mod 2^16. `illegal`=0, insn_len=3.
- Illegal RETIRE: `ip_out`=ip+1 mod 2^16, `illegal`=1, insn_len=1, `z80fi_valid`=0.
- RETIRE always → IDLE next cycle. insn[31:24] is always 0.

## Timing
- Reset (async assert, sync deassert in the system): state=IDLE; all outputs 0, including `ip_out`, `mem_addr`, and every z80fi field. Reset mid-fetch drops `mem_rd` immediately and abandons the instruction with no `done`.
- Zero wait states, `start` accepted at edge k: FETCH_OP in cycle k+1, FETCH_LO k+2, FETCH_HI k+3, RETIRE k+4, IDLE k+5. Latency 4 cycles, issue rate one instruction per 5 cycles.
- Each `mem_ready`=0 cycle extends the current fetch by one cycle. `mem_addr` and `mem_rd` are held stable while waiting.
- `done`, `z80fi_valid`, and the record fields are driven from registers and are valid only in the RETIRE cycle. Fields are zero in all other cycles.
- A `start` in the RETIRE cycle is ignored; the earliest acceptance is in the following IDLE cycle.

## Configuration
- `Z80FI_EN` defined: the z80fi_* outputs are driven as specified.
- `Z80FI_EN` undefined: the z80fi_* ports remain present but are tied to constant 0, and their registers are not built. `done`, `illegal`, `ip_out`, and the memory port are unaffected.

## Test plan
- ip=0x1000, F=0x40, mem C2 34 12 (JP NZ), zero wait -> reads 1000/1001/1002; RETIRE at k+4; ip_out=0x1003; z80fi_insn=0x001234C2, len=3.
- ip=0x1000, F=0x40, mem CA 34 12 (JP Z) -> ip_out=0x1234, z80fi_valid=1, reg_ip_in=0x1000, reg_f_in=0x40.
- All 8 cc with F=0x00 and F=0xC5 -> jump taken exactly per the cc/flag mapping. Example: cc=6 (P) with F=0xC5 -> ip_out=ip+3.
- ip=0xFFFF, mem DA 00 80 (JP C), F=0x01, mem_ready low 2 cycles on each byte -> addresses FFFF/0000/0001 held during the waits; ip_out=0x8000; RETIRE at k+10.
- Opcode 0x00 at 0x2000 -> RETIRE at k+2, illegal=1, ip_out=0x2001, z80fi_valid=0, only one read issued.
- reset_n low during FETCH_LO -> mem_rd=0 immediately, no done; a new start after release executes normally.
